// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: two-write, multi-read register file with per-register pending bits
module regfile_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD = 2,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we0,
  input  logic [AW-1:0]       addrD0,
  input  logic [XLEN-1:0]     dataD0,
  input  logic                we1,
  input  logic [AW-1:0]       addrD1,
  input  logic [XLEN-1:0]     dataD1,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  output logic [NREG-1:0]     busy_vec
);
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy, wclr, rset;
  assign wclr = (NREG'(we0) << addrD0) | (NREG'(we1) << addrD1);
  assign rset = NREG'(rsv_en) << rsv_addr;
  assign busy_vec = busy;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) regs[k] <= '0;
      busy <= '0;
    end else begin
      if (we0 && addrD0 != '0) regs[addrD0] <= dataD0;
      if (we1 && addrD1 != '0) regs[addrD1] <= dataD1;
      busy <= ((busy & ~wclr) | rset) & ~NREG'(1);
    end
  end
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic h0, h1;
    assign a = raddr[i*AW +: AW];
    assign h0 = BYPASS != 0 && we0 && addrD0 == a;
    assign h1 = BYPASS != 0 && we1 && addrD1 == a;
    assign rdata[i*XLEN +: XLEN] = a == '0 ? '0 : h1 ? dataD1 : h0 ? dataD0 : regs[a];
    assign rbusy[i] = a != '0 && !(h0 || h1) && busy[a];
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed checks of bypassing and non-bypassing register file instances
module tb_regfile_scoreboard;
  logic clk = 0, rst = 1;
  logic we0 = 0, we1 = 0, rsv_en = 0;
  logic [4:0] addrD0 = 0, addrD1 = 0, rsv_addr = 0;
  logic [31:0] dataD0 = 0, dataD1 = 0;
  logic [9:0] raddr = 0;
  logic [63:0] rdata_b, rdata_n;
  logic [1:0] rbusy_b, rbusy_n;
  logic [31:0] busy_b, busy_n;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .we0(we0), .addrD0(addrD0), .dataD0(dataD0),
    .we1(we1), .addrD1(addrD1), .dataD1(dataD1), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b), .busy_vec(busy_b));
  regfile_scoreboard #(.BYPASS(0)) u_nob (
    .clk(clk), .rst(rst), .we0(we0), .addrD0(addrD0), .dataD0(dataD0),
    .we1(we1), .addrD1(addrD1), .dataD1(dataD1), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n), .busy_vec(busy_n));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; rsv_en = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    we0 = 1; addrD0 = 2; dataD0 = 32'h5; rsv_en = 1; rsv_addr = 2;
    tick(); tick();
    rst = 0; idle();
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(31 - a), 5'(a)};
      #1;
      tests++;
      if (rdata_b !== 64'h0 || rdata_n !== 64'h0 || rbusy_b !== 2'b0 || rbusy_n !== 2'b0) begin
        fails++;
        $display("FAIL reset_read a=%0d rdata_b=%h rdata_n=%h rbusy=%b/%b expected 0", a, rdata_b, rdata_n, rbusy_b, rbusy_n);
      end
    end
    tests++;
    if (busy_b !== 32'h0 || busy_n !== 32'h0) begin
      fails++;
      $display("FAIL reset_busy got %h/%h expected 0", busy_b, busy_n);
    end
  endtask

  task automatic test_write_conflict();
    we0 = 1; addrD0 = 5; dataD0 = 32'h11111111;
    we1 = 1; addrD1 = 5; dataD1 = 32'hdeadbeef;
    raddr = {5'd5, 5'd5};
    #1;
    tests++;
    if (rdata_b !== {32'hdeadbeef, 32'hdeadbeef}) begin
      fails++;
      $display("FAIL conflict_bypass got %h expected deadbeefdeadbeef", rdata_b);
    end
    tests++;
    if (rdata_n !== 64'h0) begin
      fails++;
      $display("FAIL conflict_nobypass_old got %h expected 0", rdata_n);
    end
    tick(); idle(); #1;
    tests++;
    if (rdata_b !== {32'hdeadbeef, 32'hdeadbeef} || rdata_n !== {32'hdeadbeef, 32'hdeadbeef}) begin
      fails++;
      $display("FAIL conflict_stored got %h/%h expected deadbeef", rdata_b, rdata_n);
    end
  endtask

  task automatic test_x0();
    we0 = 1; addrD0 = 0; dataD0 = 32'hffffffff; rsv_en = 1; rsv_addr = 0;
    raddr = {5'd5, 5'd0};
    #1;
    tests++;
    if (rdata_b[31:0] !== 32'h0 || rbusy_b[0] !== 1'b0) begin
      fails++;
      $display("FAIL x0_same_cycle got %h busy %b expected 0", rdata_b[31:0], rbusy_b[0]);
    end
    tick(); idle(); #1;
    tests++;
    if (rdata_b[31:0] !== 32'h0 || rdata_n[31:0] !== 32'h0 || busy_b[0] !== 1'b0 || busy_b !== 32'h0) begin
      fails++;
      $display("FAIL x0_after got %h/%h busy %h expected 0", rdata_b[31:0], rdata_n[31:0], busy_b);
    end
  endtask

  task automatic test_scoreboard();
    rsv_en = 1; rsv_addr = 7;
    tick(); idle();
    raddr = {5'd7, 5'd5};
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (rbusy_b !== 2'b10 || rbusy_n !== 2'b10 || busy_b !== 32'h80) begin
        fails++;
        $display("FAIL sb_pending cycle=%0d rbusy=%b/%b busy=%h expected 10/10/00000080", c, rbusy_b, rbusy_n, busy_b);
      end
      tick();
    end
    tests++;
    if (rdata_b[31:0] !== 32'hdeadbeef) begin
      fails++;
      $display("FAIL sb_port0_indep got %h expected deadbeef", rdata_b[31:0]);
    end
    we0 = 1; addrD0 = 7; dataD0 = 32'h0000abcd;
    #1;
    tests++;
    if (rbusy_b[1] !== 1'b0 || rdata_b[63:32] !== 32'h0000abcd || rbusy_n[1] !== 1'b1 || rdata_n[63:32] !== 32'h0) begin
      fails++;
      $display("FAIL sb_write_cycle rbusy=%b/%b data=%h/%h expected 0/1 0000abcd/0", rbusy_b[1], rbusy_n[1], rdata_b[63:32], rdata_n[63:32]);
    end
    tick(); idle(); #1;
    tests++;
    if (busy_b[7] !== 1'b0 || busy_n[7] !== 1'b0 || rdata_b[63:32] !== 32'h0000abcd || rdata_n[63:32] !== 32'h0000abcd) begin
      fails++;
      $display("FAIL sb_after busy=%b/%b data=%h/%h expected 0 0000abcd", busy_b[7], busy_n[7], rdata_b[63:32], rdata_n[63:32]);
    end
  endtask

  task automatic test_collision();
    rsv_en = 1; rsv_addr = 9; we1 = 1; addrD1 = 9; dataD1 = 32'h12345678;
    raddr = {5'd7, 5'd9};
    tick(); idle(); #1;
    tests++;
    if (busy_b[9] !== 1'b1 || rbusy_b[0] !== 1'b1 || rdata_b[31:0] !== 32'h12345678 || rdata_n[31:0] !== 32'h12345678) begin
      fails++;
      $display("FAIL collision busy=%b rbusy=%b data=%h/%h expected 1 1 12345678", busy_b[9], rbusy_b[0], rdata_b[31:0], rdata_n[31:0]);
    end
    rsv_en = 1; rsv_addr = 9;
    tick(); idle();
    we0 = 1; addrD0 = 9; dataD0 = 32'h9;
    tick(); idle(); #1;
    tests++;
    if (busy_b[9] !== 1'b0 || rbusy_b[0] !== 1'b0 || rdata_b[31:0] !== 32'h9) begin
      fails++;
      $display("FAIL rereserve_clear busy=%b data=%h expected 0 00000009", busy_b[9], rdata_b[31:0]);
    end
  endtask

  task automatic test_mid_reset();
    rsv_en = 1; rsv_addr = 3;
    tick(); idle();
    we0 = 1; addrD0 = 4; dataD0 = 32'h55;
    tick(); idle();
    raddr = {5'd3, 5'd4};
    we1 = 1; addrD1 = 4; dataD1 = 32'h66;
    #1;
    tests++;
    if (rdata_n[31:0] !== 32'h55 || rdata_b[31:0] !== 32'h66) begin
      fails++;
      $display("FAIL bypass_sel nob=%h byp=%h expected 00000055/00000066", rdata_n[31:0], rdata_b[31:0]);
    end
    tests++;
    if (rbusy_b[1] !== 1'b1 || busy_n[3] !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_busy rbusy=%b busy=%b expected 1", rbusy_b[1], busy_n[3]);
    end
    rst = 1; rsv_en = 1; rsv_addr = 6;
    tick(); rst = 0; idle(); #1;
    tests++;
    if (rdata_b !== 64'h0 || rdata_n !== 64'h0 || busy_b !== 32'h0 || busy_n !== 32'h0) begin
      fails++;
      $display("FAIL mid_reset data=%h/%h busy=%h/%h expected 0", rdata_b, rdata_n, busy_b, busy_n);
    end
    we0 = 1; addrD0 = 3; dataD0 = 32'h77;
    tick(); idle(); #1;
    tests++;
    if (rdata_b[63:32] !== 32'h77 || rdata_n[63:32] !== 32'h77 || busy_b !== 32'h0 || rbusy_n !== 2'b0) begin
      fails++;
      $display("FAIL post_reset_write data=%h/%h busy=%h expected 00000077 0", rdata_b[63:32], rdata_n[63:32], busy_b);
    end
  endtask

  initial begin
    test_reset();
    test_write_conflict();
    test_x0();
    test_scoreboard();
    test_collision();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
